// File: rtl/exe_stage.sv
// RV32I execute stage: operand select, ALU, branch/jump resolution and the EX/M pipeline register.
module exe_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] inst_DE,
    input  logic [31:0] pc_DE,
    input  logic [31:0] rdata1_E,
    input  logic [31:0] rdata2_E,
    input  logic [31:0] imm_E,
    input  logic [4:0]  rd_E,
    input  logic [3:0]  alu_ctrl,
    output logic [31:0] inst_EXM,
    output logic [31:0] alu_res_M,
    output logic [31:0] rdata2_M,
    output logic [31:0] imm_M,
    output logic [4:0]  rd_M,
    output logic [31:0] pc_M,
    output logic        jump,
    output logic        branch_taken,
    output logic [31:0] pc_target,
    output logic        redirect
);
    localparam int unsigned XLEN = 32;
    localparam int unsigned RW   = 5;

    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_BRA   = 7'b1100011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_ALUI  = 7'b0010011;

    logic [XLEN-1:0] inst_q, inst_d, alu_q, alu_d, rd2_q, rd2_d, imm_q, imm_d;
    logic [XLEN-1:0] pc_q, pc_d, tgt_q, tgt_d;
    logic [RW-1:0]   rd_q, rd_d;
    logic            jump_q, jump_d, taken_q, taken_d, redir_q, redir_d, kill_q, kill_d;

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic            is_jal, is_jalr, is_bra, is_mem;
    logic [XLEN-1:0] op_a, op_b, alu_out, link, target;
    logic [3:0]      ctrl;
    logic [4:0]      shamt;
    logic            br_cond;

    // Decode and operand selection
    always_comb begin
        opcode  = inst_DE[6:0];
        funct3  = inst_DE[14:12];
        is_jal  = (opcode == OP_JAL);
        is_jalr = (opcode == OP_JALR);
        is_bra  = (opcode == OP_BRA);
        is_mem  = (opcode == OP_LOAD) || (opcode == OP_STORE);
        op_a    = rdata1_E;
        if (opcode == OP_AUIPC || is_jal || is_jalr) op_a = pc_DE;
        else if (opcode == OP_LUI)                    op_a = '0;
        op_b    = rdata2_E;
        if (opcode == OP_ALUI || is_mem || opcode == OP_AUIPC || opcode == OP_LUI) op_b = imm_E;
        ctrl    = is_mem ? 4'b0000 : alu_ctrl;
        shamt   = op_b[4:0];
    end

    // ALU
    always_comb begin
        alu_out = '0;
        unique case (ctrl)
            4'b0000: alu_out = op_a + op_b;
            4'b1000: alu_out = op_a - op_b;
            4'b0001: alu_out = op_a & op_b;
            4'b0010: alu_out = op_a | op_b;
            4'b0100: alu_out = op_a ^ op_b;
            4'b0101: alu_out = op_a << shamt;
            4'b0110: alu_out = op_a >> shamt;
            4'b1110: alu_out = XLEN'($signed(op_a) >>> shamt);
            4'b1001: alu_out = XLEN'($signed(op_a) < $signed(op_b));
            4'b1010: alu_out = XLEN'(op_a < op_b);
            default: alu_out = '0;
        endcase
    end

    // Branch condition, link address and control-transfer target
    always_comb begin
        br_cond = 1'b0;
        case (funct3)
            3'b000:  br_cond = (rdata1_E == rdata2_E);
            3'b001:  br_cond = (rdata1_E != rdata2_E);
            3'b100:  br_cond = ($signed(rdata1_E) <  $signed(rdata2_E));
            3'b101:  br_cond = ($signed(rdata1_E) >= $signed(rdata2_E));
            3'b110:  br_cond = (rdata1_E <  rdata2_E);
            3'b111:  br_cond = (rdata1_E >= rdata2_E);
            default: br_cond = 1'b0;
        endcase
        link   = pc_DE + XLEN'(4);
        target = is_jalr ? ((rdata1_E + imm_E) & ~XLEN'(1)) : (pc_DE + imm_E);
    end

    // Next EX/M register contents: hold on stall, bubble on flush/kill/empty, else capture
    always_comb begin
        inst_d  = inst_q;
        alu_d   = alu_q;
        rd2_d   = rd2_q;
        imm_d   = imm_q;
        rd_d    = rd_q;
        pc_d    = pc_q;
        tgt_d   = tgt_q;
        jump_d  = jump_q;
        taken_d = taken_q;
        redir_d = redir_q;
        kill_d  = kill_q;
        if (!stall) begin
            kill_d = 1'b0;
            if (flush || kill_q || inst_DE == '0) begin
                inst_d  = '0;
                alu_d   = '0;
                rd2_d   = '0;
                imm_d   = '0;
                rd_d    = '0;
                jump_d  = 1'b0;
                taken_d = 1'b0;
                redir_d = 1'b0;
            end else begin
                inst_d  = inst_DE;
                alu_d   = (is_jal || is_jalr) ? link : alu_out;
                rd2_d   = rdata2_E;
                imm_d   = imm_E;
                rd_d    = rd_E;
                pc_d    = pc_DE;
                tgt_d   = target;
                jump_d  = is_jal || is_jalr;
                taken_d = is_bra && br_cond;
                redir_d = jump_d || taken_d;
                kill_d  = jump_d || taken_d;
            end
        end
    end

    // EX/M pipeline register with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inst_q  <= '0;
            alu_q   <= '0;
            rd2_q   <= '0;
            imm_q   <= '0;
            rd_q    <= '0;
            pc_q    <= RESET_PC;
            tgt_q   <= RESET_PC;
            jump_q  <= 1'b0;
            taken_q <= 1'b0;
            redir_q <= 1'b0;
            kill_q  <= 1'b0;
        end else begin
            inst_q  <= inst_d;
            alu_q   <= alu_d;
            rd2_q   <= rd2_d;
            imm_q   <= imm_d;
            rd_q    <= rd_d;
            pc_q    <= pc_d;
            tgt_q   <= tgt_d;
            jump_q  <= jump_d;
            taken_q <= taken_d;
            redir_q <= redir_d;
            kill_q  <= kill_d;
        end
    end

    assign inst_EXM     = inst_q;
    assign alu_res_M    = alu_q;
    assign rdata2_M     = rd2_q;
    assign imm_M        = imm_q;
    assign rd_M         = rd_q;
    assign pc_M         = pc_q;
    assign jump         = jump_q;
    assign branch_taken = taken_q;
    assign pc_target    = tgt_q;
    assign redirect     = redir_q;

endmodule

// File: tb/tb_exe_stage.sv
// Directed scoreboard bench for exe_stage.
module tb_exe_stage;
    localparam logic [31:0] RST_PC = 32'h0000_0080;

    logic        clk, rst, stall, flush;
    logic [31:0] inst_DE, pc_DE, rdata1_E, rdata2_E, imm_E;
    logic [4:0]  rd_E;
    logic [3:0]  alu_ctrl;
    logic [31:0] inst_EXM, alu_res_M, rdata2_M, imm_M, pc_M, pc_target;
    logic [4:0]  rd_M;
    logic        jump, branch_taken, redirect;

    typedef struct {
        string       tag;
        logic [31:0] inst, alu, rd2, imm, pc, tgt;
        logic [4:0]  rd;
        logic        jmp, bt, redir, chk_tgt;
    } exp_t;

    exp_t exp_q[$];
    exp_t last;
    int   n_cmp  = 0;
    int   n_fail = 0;

    exe_stage #(.RESET_PC(RST_PC)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .inst_DE(inst_DE), .pc_DE(pc_DE), .rdata1_E(rdata1_E), .rdata2_E(rdata2_E),
        .imm_E(imm_E), .rd_E(rd_E), .alu_ctrl(alu_ctrl),
        .inst_EXM(inst_EXM), .alu_res_M(alu_res_M), .rdata2_M(rdata2_M), .imm_M(imm_M),
        .rd_M(rd_M), .pc_M(pc_M), .jump(jump), .branch_taken(branch_taken),
        .pc_target(pc_target), .redirect(redirect)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cmp32(input string tag, input string fld, input logic [31:0] obs, input logic [31:0] want);
        n_cmp++;
        assert (obs === want) else begin
            n_fail++;
            $error("FAIL %s.%s observed=%h expected=%h", tag, fld, obs, want);
        end
    endtask

    task automatic check(input exp_t e);
        cmp32(e.tag, "inst", inst_EXM, e.inst);
        cmp32(e.tag, "alu", alu_res_M, e.alu);
        cmp32(e.tag, "rdata2", rdata2_M, e.rd2);
        cmp32(e.tag, "imm", imm_M, e.imm);
        cmp32(e.tag, "rd", 32'(rd_M), 32'(e.rd));
        cmp32(e.tag, "pc", pc_M, e.pc);
        cmp32(e.tag, "jump", 32'(jump), 32'(e.jmp));
        cmp32(e.tag, "taken", 32'(branch_taken), 32'(e.bt));
        cmp32(e.tag, "redirect", 32'(redirect), 32'(e.redir));
        if (e.chk_tgt) cmp32(e.tag, "target", pc_target, e.tgt);
    endtask

    task automatic drive(input logic [31:0] inst, input logic [31:0] pc, input logic [31:0] r1,
                         input logic [31:0] r2, input logic [31:0] imm, input logic [4:0] rd,
                         input logic [3:0] ctrl, input logic st, input logic fl);
        inst_DE = inst; pc_DE = pc; rdata1_E = r1; rdata2_E = r2;
        imm_E = imm; rd_E = rd; alu_ctrl = ctrl; stall = st; flush = fl;
    endtask

    function automatic exp_t mk(input string tag, input logic [31:0] inst, input logic [31:0] alu,
                                input logic [31:0] rd2, input logic [31:0] imm, input logic [4:0] rd,
                                input logic [31:0] pc, input logic jmp, input logic bt,
                                input logic [31:0] tgt, input logic chk_tgt);
        exp_t e;
        e.tag = tag; e.inst = inst; e.alu = alu; e.rd2 = rd2; e.imm = imm; e.rd = rd;
        e.pc = pc; e.jmp = jmp; e.bt = bt; e.redir = jmp | bt; e.tgt = tgt; e.chk_tgt = chk_tgt;
        return e;
    endfunction

    // Bubble: data cleared, PC and target retained from the previous capture
    function automatic exp_t bubble(input string tag, input exp_t prev);
        return mk(tag, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, prev.pc, 1'b0, 1'b0, prev.tgt, 1'b1);
    endfunction

    task automatic push(input exp_t e);
        exp_q.push_back(e);
        last = e;
    endtask

    // Advance one edge and score the oldest outstanding expectation
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        n_cmp++;
        assert (exp_q.size() != 0) else begin
            n_fail++;
            $error("FAIL scoreboard observed=empty expected=entry");
        end
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check(e);
        end
    endtask

    initial begin
        exp_t rst_e;
        rst = 1'b1;
        drive(32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 4'h0, 1'b0, 1'b0);
        #1 rst = 1'b0;
        #1;
        rst_e = mk("reset", 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, RST_PC, 1'b0, 1'b0, RST_PC, 1'b1);
        check(rst_e);
        last = rst_e;
        @(posedge clk); #1;
        rst = 1'b1;

        drive(32'h002081B3, 32'h10, 32'd7, 32'd5, 32'h0, 5'd3, 4'b0000, 1'b0, 1'b0);
        push(mk("add", 32'h002081B3, 32'd12, 32'd5, 32'h0, 5'd3, 32'h10, 1'b0, 1'b0, 32'h0, 1'b0));
        tick();

        drive(32'h4020D233, 32'h14, 32'h8000_0000, 32'd33, 32'h0, 5'd4, 4'b1110, 1'b0, 1'b0);
        push(mk("sra", 32'h4020D233, 32'hC000_0000, 32'd33, 32'h0, 5'd4, 32'h14, 1'b0, 1'b0, 32'h0, 1'b0));
        tick();

        drive(32'h0010B293, 32'h18, 32'hFFFF_FFFF, 32'h55, 32'h1, 5'd5, 4'b1010, 1'b0, 1'b0);
        push(mk("sltu", 32'h0010B293, 32'h0, 32'h55, 32'h1, 5'd5, 32'h18, 1'b0, 1'b0, 32'h0, 1'b0));
        tick();

        drive(32'h402081B3, 32'h1C, 32'd3, 32'd5, 32'h0, 5'd3, 4'b1000, 1'b0, 1'b0);
        push(mk("sub", 32'h402081B3, 32'hFFFF_FFFE, 32'd5, 32'h0, 5'd3, 32'h1C, 1'b0, 1'b0, 32'h0, 1'b0));
        tick();

        drive(32'h12345337, 32'h20, 32'h0000_DEAD, 32'h0, 32'h1234_5000, 5'd6, 4'b0000, 1'b0, 1'b0);
        push(mk("lui", 32'h12345337, 32'h1234_5000, 32'h0, 32'h1234_5000, 5'd6, 32'h20, 1'b0, 1'b0, 32'h0, 1'b0));
        tick();

        drive(32'h00001397, 32'h24, 32'h0000_BEEF, 32'h0, 32'h0000_1000, 5'd7, 4'b0000, 1'b0, 1'b0);
        push(mk("auipc", 32'h00001397, 32'h0000_1024, 32'h0, 32'h0000_1000, 5'd7, 32'h24, 1'b0, 1'b0, 32'h0, 1'b0));
        tick();

        drive(32'hFE20CCE3, 32'h100, 32'hFFFF_FFFF, 32'h0, 32'hFFFF_FFF8, 5'd0, 4'b0000, 1'b0, 1'b0);
        push(mk("blt", 32'hFE20CCE3, 32'hFFFF_FFFF, 32'h0, 32'hFFFF_FFF8, 5'd0, 32'h100, 1'b0, 1'b1, 32'hF8, 1'b1));
        tick();

        drive(32'h002081B3, 32'h104, 32'd1, 32'd1, 32'h0, 5'd3, 4'b0000, 1'b0, 1'b0);
        push(bubble("blt_kill", last));
        tick();

        drive(32'h004080E7, 32'h40, 32'h203, 32'h9, 32'h4, 5'd1, 4'b0000, 1'b0, 1'b0);
        push(mk("jalr", 32'h004080E7, 32'h44, 32'h9, 32'h4, 5'd1, 32'h40, 1'b1, 1'b0, 32'h206, 1'b1));
        tick();

        drive(32'h00208463, 32'h44, 32'd1, 32'd1, 32'h8, 5'd0, 4'b0000, 1'b0, 1'b0);
        push(bubble("jalr_kill", last));
        tick();

        drive(32'h00208463, 32'h50, 32'd1, 32'd2, 32'h8, 5'd0, 4'b0000, 1'b0, 1'b0);
        push(mk("beq_nt", 32'h00208463, 32'd3, 32'd2, 32'h8, 5'd0, 32'h50, 1'b0, 1'b0, 32'h0, 1'b0));
        tick();

        drive(32'h020000EF, 32'h60, 32'h0, 32'h0, 32'h20, 5'd1, 4'b0000, 1'b0, 1'b0);
        push(mk("jal", 32'h020000EF, 32'h64, 32'h0, 32'h20, 5'd1, 32'h60, 1'b1, 1'b0, 32'h80, 1'b1));
        tick();

        drive(32'h0, 32'h64, 32'h0, 32'h0, 32'h0, 5'd0, 4'b0000, 1'b0, 1'b0);
        push(bubble("jal_kill", last));
        tick();

        drive(32'h002081B3, 32'h68, 32'd4, 32'd4, 32'h0, 5'd3, 4'b0000, 1'b0, 1'b1);
        push(bubble("flush", last));
        tick();

        drive(32'h0020F463, 32'h70, 32'd1, 32'hFFFF_FFFF, 32'h8, 5'd0, 4'b0000, 1'b0, 1'b0);
        push(mk("bgeu_nt", 32'h0020F463, 32'h0, 32'hFFFF_FFFF, 32'h8, 5'd0, 32'h70, 1'b0, 1'b0, 32'h0, 1'b0));
        tick();

        drive(32'h00C0A403, 32'h74, 32'h1000, 32'h77, 32'hC, 5'd8, 4'b0101, 1'b0, 1'b0);
        push(mk("lw", 32'h00C0A403, 32'h100C, 32'h77, 32'hC, 5'd8, 32'h74, 1'b0, 1'b0, 32'h0, 1'b0));
        tick();

        for (int i = 0; i < 3; i++) begin
            drive(32'h002081B3, 32'h78 + 32'(i), 32'd9, 32'd9, 32'h0, 5'd3, 4'b0000, 1'b1, i == 1);
            last.tag = "stall_hold";
            push(last);
            tick();
        end

        drive(32'h002081B3, 32'h78, 32'd1, 32'd2, 32'h0, 5'd3, 4'b0000, 1'b0, 1'b0);
        push(mk("release", 32'h002081B3, 32'd3, 32'd2, 32'h0, 5'd3, 32'h78, 1'b0, 1'b0, 32'h0, 1'b0));
        tick();

        drive(32'h010000EF, 32'h200, 32'h0, 32'h0, 32'h10, 5'd1, 4'b0000, 1'b0, 1'b0);
        push(mk("jal2", 32'h010000EF, 32'h204, 32'h0, 32'h10, 5'd1, 32'h200, 1'b1, 1'b0, 32'h210, 1'b1));
        tick();

        drive(32'h002081B3, 32'h204, 32'd1, 32'd1, 32'h0, 5'd3, 4'b0000, 1'b1, 1'b0);
        last.tag = "jal2_stall";
        push(last);
        tick();

        #2 rst = 1'b0;
        #1;
        rst_e.tag = "reset_mid";
        check(rst_e);
        last = rst_e;
        @(posedge clk); #1;
        rst = 1'b1;

        drive(32'h002081B3, 32'h300, 32'd20, 32'd22, 32'h0, 5'd3, 4'b0000, 1'b0, 1'b0);
        push(mk("post_reset", 32'h002081B3, 32'd42, 32'd22, 32'h0, 5'd3, 32'h300, 1'b0, 1'b0, 32'h0, 1'b0));
        tick();

        n_cmp++;
        assert (exp_q.size() == 0) else begin
            n_fail++;
            $error("FAIL drain observed=%0d expected=0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
